// File: rtl/line_loader.sv
// line_loader
//
// Refills the per-line timestamp/active-pixel memories of the timing core
// from a host word stream. One line is written into the current target bank,
// then the loader waits for the core's update_mem request, commits the bank
// with a one-cycle mem_updated pulse and moves on to the next bank
// (round-robin over NUM_MEMS banks).
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   enable_i              1 = run, 0 = abort to IDLE
//   points_per_line_i     words per line, sampled when a line starts
//   s_data_i/s_valid_i    host word stream; s_ready_o accepts it
//   update_mem_i          core request for the next line (rising edge used)
//   mem_updated_o         one-cycle pulse: bank committed to the core
//   waddr_o/wdata_o/we_o  memory write port
//   memory_selector_o     target bank
//   busy_o                loader not idle
//   late_o                sticky: request came before the line was complete
//   lines_loaded_o        committed-line counter (wraps at 2^16)
module line_loader #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 17,
    parameter int NUM_MEMS = 8,
    parameter int SEL_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [ADDR_W-1:0] points_per_line_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic              update_mem_i,
    output logic              mem_updated_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic [SEL_W-1:0]  memory_selector_o,
    output logic              busy_o,
    output logic              late_o,
    output logic [15:0]       lines_loaded_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [SEL_W-1:0] BANK_ONE = SEL_W'(1);
    localparam logic [SEL_W-1:0] BANK_MAX = SEL_W'(NUM_MEMS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   plen_q;
    // One bit wider than the address so a maximum-length line never wraps.
    logic [ADDR_W:0]     cnt_q;
    logic [SEL_W-1:0]    bank_q;
    logic                pend_q;
    logic                upd_q;
    logic                late_q;
    logic [15:0]         lines_q;
    logic                we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                mu_q;

    logic req;
    logic accept;
    logic last_word;
    logic abort;
    logic commit;
    logic enter_load;
    logic late_req;

    assign req       = update_mem_i & ~upd_q;
    assign s_ready_o = (state_q == LOAD);
    // A zero-length line accepts nothing even though ready is up for its
    // single LOAD cycle.
    assign accept    = s_valid_i & s_ready_o & (plen_q != '0);
    assign last_word = accept & ((cnt_q + CNT_ONE) == {1'b0, plen_q});
    assign abort     = (state_q != IDLE) & ~enable_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        commit     = 1'b0;
        enter_load = 1'b0;
        late_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d    = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else begin
                    if ((plen_q == '0) || last_word) begin
                        state_d = FULL;
                    end
                    // Early request: remember it and commit on the first FULL cycle.
                    late_req = req;
                end
            end
            FULL: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (req || pend_q) begin
                    commit     = 1'b1;
                    state_d    = LOAD;
                    enter_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            bank_q  <= '0;
            pend_q  <= 1'b0;
            upd_q   <= 1'b0;
            late_q  <= 1'b0;
            lines_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            mu_q    <= 1'b0;
        end else begin
            upd_q <= update_mem_i;
            mu_q  <= commit;
            we_q  <= accept;
            if (accept) begin
                waddr_q <= cnt_q[ADDR_W-1:0];
                wdata_q <= s_data_i;
                cnt_q   <= cnt_q + CNT_ONE;
            end
            if (enter_load || abort) begin
                cnt_q <= '0;
            end
            if (abort || commit) begin
                pend_q <= 1'b0;
            end else if (late_req) begin
                pend_q <= 1'b1;
            end
            if (late_req) begin
                late_q <= 1'b1;
            end
            if (commit) begin
                bank_q  <= (bank_q == BANK_MAX) ? '0 : bank_q + BANK_ONE;
                lines_q <= lines_q + 16'd1;
            end
        end
    end

    // Line length is only meaningful inside LOAD, so it is not reset.
    always_ff @(posedge clk_i) begin
        if (enter_load) begin
            plen_q <= points_per_line_i;
        end
    end

    assign mem_updated_o     = mu_q;
    assign waddr_o           = waddr_q;
    assign wdata_o           = wdata_q;
    assign we_o              = we_q;
    assign memory_selector_o = bank_q;
    assign busy_o            = (state_q != IDLE);
    assign late_o            = late_q;
    assign lines_loaded_o    = lines_q;

endmodule

// File: tb/tb_line_loader.sv
module tb_line_loader;

    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 17;
    localparam int NUM_MEMS = 8;
    localparam int SEL_W    = 3;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              enable_i;
    logic [ADDR_W-1:0] points_per_line_i;
    logic [DATA_W-1:0] s_data_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic              update_mem_i;
    logic              mem_updated_o;
    logic [ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0] wdata_o;
    logic              we_o;
    logic [SEL_W-1:0]  memory_selector_o;
    logic              busy_o;
    logic              late_o;
    logic [15:0]       lines_loaded_o;

    line_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_MEMS(NUM_MEMS), .SEL_W(SEL_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
        .points_per_line_i(points_per_line_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .update_mem_i(update_mem_i), .mem_updated_o(mem_updated_o),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
        .memory_selector_o(memory_selector_o), .busy_o(busy_o),
        .late_o(late_o), .lines_loaded_o(lines_loaded_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int mu_cnt  = 0;
    int bank_m  = 0;
    logic [28:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest expected word.
    always @(negedge clk) begin
        if (mem_updated_o === 1'b1) mu_cnt++;
        if (we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {3'b0, memory_selector_o, waddr_o, wdata_o}, 32'hFFFF_FFFF);
            end else begin
                chk("wr", {3'b0, memory_selector_o, waddr_o, wdata_o}, {3'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n words with s_valid held; expects s_ready within 20 cycles.
    task automatic send_words(input int n, input int base, input int start);
        int w;
        w = 0;
        while (s_ready_o !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (w == 20) chk("ready_timeout", 0, 1);
        for (int i = 0; i < n; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = DATA_W'(base + i);
            exp_q.push_back({SEL_W'(bank_m), ADDR_W'(start + i), DATA_W'(base + i)});
            tick();
        end
        s_valid_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdy"},   s_ready_o, 0);
        chk({tag, "_mu"},    mem_updated_o, 0);
        chk({tag, "_we"},    we_o, 0);
        chk({tag, "_waddr"}, waddr_o, 0);
        chk({tag, "_wdata"}, wdata_o, 0);
        chk({tag, "_sel"},   memory_selector_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_late"},  late_o, 0);
        chk({tag, "_lines"}, lines_loaded_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mu0;
        rst_i = 1'b1; enable_i = 1'b0; points_per_line_i = '0;
        s_data_i = '0; s_valid_i = 1'b0; update_mem_i = 1'b0;
        tick(); tick();
        check_zero("reset");
        rst_i = 1'b0;

        // Basic 4-word line into bank 0.
        enable_i = 1'b1; points_per_line_i = 9'd4;
        tick();
        send_words(4, 'h100, 0);
        chk("full_rdy", s_ready_o, 0);
        chk("full_busy", busy_o, 1);

        // Held request -> single commit one cycle later.
        mu0 = mu_cnt;
        update_mem_i = 1'b1;
        tick();
        chk("commit_mu", mem_updated_o, 1);
        chk("commit_rdy", s_ready_o, 1);
        chk("commit_sel", memory_selector_o, 1);
        chk("commit_lines", lines_loaded_o, 1);
        chk("commit_late", late_o, 0);
        bank_m = 1;
        tick(); tick(); tick(); tick();
        update_mem_i = 1'b0;
        chk("held_once", mu_cnt - mu0, 1);

        // Early request after 2 of 4 words.
        send_words(2, 'h200, 0);
        update_mem_i = 1'b1;
        send_words(2, 'h202, 2);
        chk("late_set", late_o, 1);
        chk("late_mu_wait", mem_updated_o, 0);
        update_mem_i = 1'b0;
        tick();
        chk("late_mu", mem_updated_o, 1);
        chk("late_lines", lines_loaded_o, 2);
        chk("late_sel", memory_selector_o, 2);
        bank_m = 2;

        // Nine 1-word lines from a fresh reset: bank wraps 7 -> 0.
        rst_i = 1'b1; enable_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0; bank_m = 0;
        enable_i = 1'b1; points_per_line_i = 9'd1;
        for (int i = 0; i < 9; i++) begin
            send_words(1, 'h10 + i, 0);
            update_mem_i = 1'b1;
            tick();
            chk("rr_mu", mem_updated_o, 1);
            chk("rr_sel", memory_selector_o, (i + 1) % NUM_MEMS);
            bank_m = (i + 1) % NUM_MEMS;
            update_mem_i = 1'b0;
        end
        chk("rr_lines", lines_loaded_o, 9);
        chk("rr_late", late_o, 0);

        // Abort after 2 words, then restart on the same bank.
        enable_i = 1'b0; tick();
        points_per_line_i = 9'd4; enable_i = 1'b1; tick();
        send_words(2, 'h300, 0);
        enable_i = 1'b0;
        tick();
        chk("abort_busy", busy_o, 0);
        chk("abort_rdy", s_ready_o, 0);
        mu0 = mu_cnt;
        enable_i = 1'b1;
        send_words(4, 'h400, 0);
        chk("restart_rdy", s_ready_o, 0);
        tick();
        chk("abort_no_mu", mu_cnt - mu0, 0);
        chk("abort_lines", lines_loaded_o, 9);
        update_mem_i = 1'b1;
        tick();
        chk("restart_mu", mem_updated_o, 1);
        chk("restart_lines", lines_loaded_o, 10);
        chk("restart_sel", memory_selector_o, 2);
        bank_m = 2;
        update_mem_i = 1'b0;

        // Zero-length line.
        enable_i = 1'b0; tick();
        points_per_line_i = 9'd0; enable_i = 1'b1; tick();
        chk("zero_load", s_ready_o, 1);
        tick();
        chk("zero_full_rdy", s_ready_o, 0);
        chk("zero_full_busy", busy_o, 1);
        update_mem_i = 1'b1;
        tick();
        chk("zero_mu", mem_updated_o, 1);
        chk("zero_lines", lines_loaded_o, 11);
        chk("zero_sel", memory_selector_o, 3);
        bank_m = 3;
        update_mem_i = 1'b0;

        // Reset in the middle of a line.
        enable_i = 1'b0; tick();
        points_per_line_i = 9'd4; enable_i = 1'b1; tick();
        send_words(2, 'h500, 0);
        rst_i = 1'b1;
        tick();
        check_zero("midrst");
        rst_i = 1'b0; enable_i = 1'b0; bank_m = 0;
        tick();
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
